// File: rtl/sccb_responder.sv
// SCCB target: answers 3-phase writes and 2-phase reads, holds a 256x8
// register file and pulses wr_strobe on every byte written into it.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | bus free, waiting for START
// ID       | shifting in the 8-bit device ID
// ID_ACK   | ACK slot after a matching ID
// REG      | shifting in the register sub-address
// REG_ACK  | ACK slot after the sub-address (pointer already loaded)
// DATA     | shifting in a write data byte
// DATA_ACK | ACK slot after a data byte (write done, pointer bumped)
// RD_DATA  | driving regs[ptr] MSB first
// RD_ACK   | master ACK/NA slot after a read byte
// IGNORE   | not addressed or read finished, waiting for START/STOP
`timescale 1ns/1ps

module sccb_responder #(
  parameter logic [6:0] DEV_ADDR = 7'h21,
  parameter int         ACK_EN   = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scl,
  inout  wire        sda,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, ID, ID_ACK, REG, REG_ACK, DATA, DATA_ACK, RD_DATA, RD_ACK, IGNORE
  } state_t;

  state_t      state, state_n;

  logic        scl_s1, scl_s2, scl_q;
  logic        sda_s1, sda_s2, sda_q;
  logic        scl_rise, scl_fall, start_c, stop_c;

  logic [3:0]  bit_cnt;
  logic        ack_phase;
  logic [7:0]  rx;
  logic [7:0]  rx_next;
  logic [7:0]  tx;
  logic [7:0]  ptr;
  logic        sda_oe;
  logic [7:0]  regs [256];

  logic        in_rx, shift_en, cnt_en, state_chg, wr_en, ptr_ld;
  logic        ack_drive, rd_load, rd_shift, rd_ack_rise, ack_set;

  // Open drain: only ever pull low; reset releases the line immediately
  // rather than waiting for the next clock edge.
  assign sda = (sda_oe && reset_n) ? 1'b0 : 1'bz;

  // Two-flop synchronisers plus one history flop for edge detection.
  // Reset to the idle-bus level so leaving reset never looks like an edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_q  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_q  <= 1'b1;
    end else begin
      scl_s1 <= scl;
      scl_s2 <= scl_s1;
      scl_q  <= scl_s2;
      sda_s1 <= sda;
      sda_s2 <= sda_s1;
      sda_q  <= sda_s2;
    end
  end

  assign scl_rise = scl_s2 & ~scl_q;
  assign scl_fall = ~scl_s2 & scl_q;
  assign start_c  = scl_s2 & scl_q & sda_q & ~sda_s2;
  assign stop_c   = scl_s2 & scl_q & ~sda_q & sda_s2;
  assign rx_next  = {rx[6:0], sda_s2};

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  // Next-state logic; START and STOP override every state.
  always_comb begin
    state_n = state;
    if (start_c) begin
      state_n = ID;
    end else if (stop_c) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE:     state_n = IDLE;
        ID:       if (scl_rise && bit_cnt == 4'd7)
                    state_n = (rx_next[7:1] == DEV_ADDR) ? ID_ACK : IGNORE;
        ID_ACK:   if (scl_fall && ack_phase)
                    state_n = rx[0] ? RD_DATA : REG;
        REG:      if (scl_rise && bit_cnt == 4'd7) state_n = REG_ACK;
        REG_ACK:  if (scl_fall && ack_phase) state_n = DATA;
        DATA:     if (scl_rise && bit_cnt == 4'd7) state_n = DATA_ACK;
        DATA_ACK: if (scl_fall && ack_phase) state_n = DATA;
        RD_DATA:  if (scl_fall && bit_cnt == 4'd8) state_n = RD_ACK;
        RD_ACK: begin
          if (scl_rise && sda_s2)        state_n = IGNORE;
          else if (scl_fall && ack_phase) state_n = RD_DATA;
        end
        IGNORE:   state_n = IGNORE;
        default:  state_n = IDLE;
      endcase
    end
  end

  // Output / datapath-control decode from current and next state.
  always_comb begin
    busy        = (state != IDLE);
    in_rx       = (state == ID) || (state == REG) || (state == DATA);
    shift_en    = scl_rise && in_rx;
    cnt_en      = scl_rise && (in_rx || state == RD_DATA);
    state_chg   = start_c || (state_n != state);
    wr_en       = (state == DATA) && (state_n == DATA_ACK);
    ptr_ld      = (state == REG) && (state_n == REG_ACK);
    ack_drive   = scl_fall && !ack_phase &&
                  ((state == ID_ACK) || (state == REG_ACK) || (state == DATA_ACK));
    rd_load     = (state_n == RD_DATA) && (state != RD_DATA);
    rd_shift    = (state == RD_DATA) && scl_fall && (state_n == RD_DATA);
    rd_ack_rise = (state == RD_ACK) && scl_rise;
    ack_set     = ack_drive || (rd_ack_rise && !sda_s2);
  end

  // Bit counter, shift registers, pointer, write report and sda drive.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bit_cnt   <= 4'd0;
      ack_phase <= 1'b0;
      rx        <= 8'h00;
      tx        <= 8'h00;
      ptr       <= 8'h00;
      sda_oe    <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= 8'h00;
      wr_data   <= 8'h00;
    end else begin
      wr_strobe <= wr_en;

      if (state_chg) begin
        bit_cnt   <= 4'd0;
        ack_phase <= 1'b0;
      end else begin
        if (cnt_en)  bit_cnt   <= bit_cnt + 4'd1;
        if (ack_set) ack_phase <= 1'b1;
      end

      if (shift_en) rx <= rx_next;

      if (rd_load)       tx <= regs[ptr];
      else if (rd_shift) tx <= {tx[6:0], 1'b0};

      if (ptr_ld)                     ptr <= rx_next;
      else if (wr_en || rd_ack_rise)  ptr <= ptr + 8'd1;

      if (wr_en) begin
        wr_addr <= ptr;
        wr_data <= rx_next;
      end

      // A 1 bit releases the line, a 0 bit pulls it low.
      if (start_c || stop_c) sda_oe <= 1'b0;
      else if (ack_drive)    sda_oe <= (ACK_EN != 0);
      else if (rd_load)      sda_oe <= ~regs[ptr][7];
      else if (rd_shift)     sda_oe <= ~tx[6];
      else if (state_chg)    sda_oe <= 1'b0;
    end
  end

  // Register file; a read load in the same cycle sees the pre-write value.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 256; i++) regs[i] <= 8'h00;
    end else if (wr_en) begin
      regs[ptr] <= rx_next;
    end
  end

endmodule

// File: tb/tb_sccb_responder.sv
// Bench for sccb_responder: bit-banged SCCB master, table of write/readback
// vectors, then hand-written sequences for burst, wrong ID, aborted byte
// and reset during ACK.
`timescale 1ns/1ps

module tb_sccb_responder;

  localparam int Q = 50;  // quarter SCL period, 5 clk

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_sda_low = 1'b0;
  wire        sda_bus;
  logic       wr_strobe;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  int n_checks = 0;
  int n_fail = 0;
  int n_strobe = 0;
  int n_drive = 0;

  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  sccb_responder dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .scl       (scl),
    .sda       (sda_bus),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (reset_n && wr_strobe) n_strobe <= n_strobe + 1;
  always @(negedge clk) if (!m_sda_low && sda_bus === 1'b0) n_drive <= n_drive + 1;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_start();
    #(Q); m_sda_low = 1'b0;
    #(Q); scl = 1'b1;
    #(Q); m_sda_low = 1'b1;
    #(Q); scl = 1'b0;
  endtask

  task automatic bus_stop();
    #(Q); m_sda_low = 1'b1;
    #(Q); scl = 1'b1;
    #(Q); m_sda_low = 1'b0;
    #(2*Q);
  endtask

  task automatic send_bit(input logic b);
    #(Q); m_sda_low = ~b;
    #(Q); scl = 1'b1;
    #(2*Q); scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    #(Q); m_sda_low = 1'b0;
    #(Q); scl = 1'b1;
    #(Q); ack = (sda_bus === 1'b0);
    #(Q); scl = 1'b0;
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] d);
    m_sda_low = 1'b0;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      #(2*Q); scl = 1'b1;
      #(Q); d = {d[6:0], (sda_bus === 1'b0) ? 1'b0 : 1'b1};
      #(Q); scl = 1'b0;
    end
    send_bit(~mack);
  endtask

  task automatic wr1(input logic [7:0] ra, input logic [7:0] d, output logic [2:0] acks);
    logic a2, a1, a0;
    bus_start();
    send_byte(8'h42, a2);
    send_byte(ra, a1);
    send_byte(d, a0);
    bus_stop();
    acks = {a2, a1, a0};
  endtask

  task automatic set_ptr(input logic [7:0] ra, output logic [1:0] acks);
    logic a1, a0;
    bus_start();
    send_byte(8'h42, a1);
    send_byte(ra, a0);
    bus_stop();
    acks = {a1, a0};
  endtask

  task automatic rd1(input logic [7:0] ra, output logic [7:0] d, output logic ok);
    logic [1:0] pa;
    logic       ia;
    set_ptr(ra, pa);
    bus_start();
    send_byte(8'h43, ia);
    recv_byte(1'b0, d);
    bus_stop();
    ok = (pa == 2'b11) && ia;
  endtask

  initial begin
    logic [2:0] acks3;
    logic [1:0] acks2;
    logic [4:0] acks5;
    logic       a, b, c, d_ack, e, ok;
    logic [7:0] rd, d0, d1, d2, idb;
    int         s0, dr0;

    vecs[0] = '{addr: 8'h12, data: 8'h80, exp_rd: 8'h80};
    vecs[1] = '{addr: 8'h10, data: 8'h77, exp_rd: 8'h77};
    vecs[2] = '{addr: 8'h00, data: 8'hFF, exp_rd: 8'hFF};
    vecs[3] = '{addr: 8'hFF, data: 8'hA5, exp_rd: 8'hA5};
    vecs[4] = '{addr: 8'h55, data: 8'h01, exp_rd: 8'h01};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_strobe", {15'd0, wr_strobe}, 16'd0);
    check("rst_wr_addr", {8'd0, wr_addr}, 16'h0000);
    check("rst_wr_data", {8'd0, wr_data}, 16'h0000);
    check("rst_sda", {15'd0, sda_bus}, 16'd1);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // single writes with readback
    for (int i = 0; i < 5; i++) begin
      s0 = n_strobe;
      wr1(vecs[i].addr, vecs[i].data, acks3);
      repeat (2) @(negedge clk);
      check("wr_acks", {13'd0, acks3}, 16'h0007);
      check("wr_strobes", 16'(n_strobe - s0), 16'd1);
      check("wr_addr", {8'd0, wr_addr}, {8'd0, vecs[i].addr});
      check("wr_data", {8'd0, wr_data}, {8'd0, vecs[i].data});
      check("busy_after_stop", {15'd0, busy}, 16'd0);
      rd1(vecs[i].addr, rd, ok);
      check("rd_acks", {15'd0, ok}, 16'd1);
      check("rd_value", {8'd0, rd}, {8'd0, vecs[i].exp_rd});
    end

    // 2-phase write sets the pointer only, then read an unwritten register
    s0 = n_strobe;
    bus_start();
    send_byte(8'h42, a);
    send_byte(8'h3A, b);
    check("busy_mid", {15'd0, busy}, 16'd1);
    bus_stop();
    check("ptr_acks", {14'd0, a, b}, 16'h0003);
    bus_start();
    send_byte(8'h43, c);
    recv_byte(1'b0, rd);
    repeat (5) @(negedge clk);
    check("na_release", {15'd0, sda_bus}, 16'd1);
    bus_stop();
    check("rd_id_ack", {15'd0, c}, 16'd1);
    check("rd_3a", {8'd0, rd}, 16'h0000);
    check("no_strobe_2ph", 16'(n_strobe - s0), 16'd0);

    // burst write wrapping past 0xFF, then burst read back
    s0 = n_strobe;
    bus_start();
    send_byte(8'h42, acks5[4]);
    send_byte(8'hFE, acks5[3]);
    send_byte(8'h11, acks5[2]);
    send_byte(8'h22, acks5[1]);
    send_byte(8'h33, acks5[0]);
    bus_stop();
    check("burst_acks", {11'd0, acks5}, 16'h001F);
    check("burst_strobes", 16'(n_strobe - s0), 16'd3);
    check("burst_wr_addr", {8'd0, wr_addr}, 16'h0000);
    check("burst_wr_data", {8'd0, wr_data}, 16'h0033);
    set_ptr(8'hFE, acks2);
    bus_start();
    send_byte(8'h43, a);
    recv_byte(1'b1, d0);
    recv_byte(1'b1, d1);
    recv_byte(1'b0, d2);
    bus_stop();
    check("burst_rd_fe", {8'd0, d0}, 16'h0011);
    check("burst_rd_ff", {8'd0, d1}, 16'h0022);
    check("burst_rd_00", {8'd0, d2}, 16'h0033);

    // foreign ID: no ACK, line never pulled, no write
    s0  = n_strobe;
    dr0 = n_drive;
    bus_start();
    send_byte(8'h44, a);
    send_byte(8'h12, b);
    bus_stop();
    check("bad_id_ack", {14'd0, a, b}, 16'h0000);
    check("bad_id_drive", 16'(n_drive - dr0), 16'd0);
    check("bad_id_strobe", 16'(n_strobe - s0), 16'd0);
    wr1(8'h20, 8'h5A, acks3);
    check("after_bad_acks", {13'd0, acks3}, 16'h0007);
    check("after_bad_data", {8'd0, wr_data}, 16'h005A);

    // data byte cut after 4 bits by STOP
    s0 = n_strobe;
    bus_start();
    send_byte(8'h42, a);
    send_byte(8'h10, b);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    bus_stop();
    check("partial_strobe", 16'(n_strobe - s0), 16'd0);
    check("partial_busy", {15'd0, busy}, 16'd0);
    rd1(8'h10, rd, ok);
    check("partial_restart", {15'd0, ok}, 16'd1);
    check("partial_reg10", {8'd0, rd}, 16'h0077);

    // reset while the responder holds the ID ACK
    idb = 8'h42;
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(idb[i]);
    repeat (2) @(negedge clk);
    m_sda_low = 1'b0;
    repeat (4) @(negedge clk);
    check("ack_before_rst", {15'd0, sda_bus}, 16'd0);
    reset_n = 1'b0;
    #1;
    check("rst_sda_now", {15'd0, sda_bus}, 16'd1);
    @(negedge clk);
    check("rst_busy_next", {15'd0, busy}, 16'd0);
    check("rst_wr_addr2", {8'd0, wr_addr}, 16'h0000);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #(Q); scl = 1'b1;
    #(Q);
    rd1(8'h12, rd, ok);
    check("clr_12", {7'd0, ok, rd}, 16'h0100);
    rd1(8'hFE, rd, ok);
    check("clr_fe", {7'd0, ok, rd}, 16'h0100);
    rd1(8'h20, rd, ok);
    check("clr_20", {7'd0, ok, rd}, 16'h0100);
    rd1(8'h10, rd, ok);
    check("clr_10", {7'd0, ok, rd}, 16'h0100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
